// File: rtl/mips_lsu_pkg.sv
// rtl/mips_lsu_pkg.sv - shared sizes, state encoding and defaults for the load/store unit
package mips_lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int ADDR_W_DEF      = 10;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  // Size 11 and any access not aligned to its own width never reach memory.
  function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == 2'b11) ||
           (size == SIZE_HALF && addr_lo[0]) ||
           (size == SIZE_WORD && addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - execute-side request/response and data-memory bus of the load/store unit
interface load_store_unit_if
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_lane_align
  import mips_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (size)
      SIZE_BYTE: load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = {{16{is_signed & half_sel[15]}}, half_sel};
      default:   load_data = rdata;
    endcase
  end

  // rdata doubles as the old word during the read half of a read-modify-write.
  always_comb begin
    merged = rdata;
    case (size)
      SIZE_BYTE: merged[{addr_lo, 3'b000} +: 8]  = wdata[7:0];
      SIZE_HALF: merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default:   merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage FSM: word-memory loads/stores with RMW sub-word stores and ack timeout
module load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e        state_q, state_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0] load_data;
  logic [31:0] merged;
  logic        unused_addr_hi;

  // Upper address bits are dropped so accesses wrap within the memory.
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  lsu_lane_align u_align (
    .rdata     (bus.mem_rdata),
    .addr_lo   (addr_lo_q),
    .size      (size_q),
    .is_signed (signed_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    size_d      = size_q;
    signed_d    = signed_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_lo_d  = bus.req_addr[1:0];
          size_d     = bus.req_size;
          signed_d   = bus.req_signed;
          write_d    = bus.req_write;
          wdata_d    = bus.req_wdata;
          mem_addr_d = bus.req_addr[ADDR_W+1:2];
          cnt_d      = '0;
          if (access_illegal(bus.req_size, bus.req_addr[1:0])) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (!bus.req_write || bus.req_size != SIZE_WORD) begin
            state_d   = S_RD;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
          end else begin
            state_d     = S_WR;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = bus.req_wdata;
          end
        end
      end
      S_RD: begin
        if (bus.mem_ack) begin
          if (!write_q) begin
            state_d   = S_RESP;
            mem_req_d = 1'b0;
            rdata_d   = load_data;
            err_d     = 1'b0;
          end else begin
            // Write phase follows the read with mem_req held high.
            state_d     = S_WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = merged;
            cnt_d       = '0;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR: begin
        if (bus.mem_ack || cnt_q == CNT_LAST) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          rdata_d   = '0;
          err_d     = !bus.mem_ack;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_lo_q   <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.stall      = (state_q == S_RD) || (state_q == S_WR);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit with a 1-cycle-ack word memory
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(10)) bus();

  load_store_unit #(.ADDR_W(10), .TIMEOUT_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Memory acks in the first cycle of each request unless hung.
  logic [31:0] mem [0:1023];
  logic        hang = 1'b0;
  int          stall_total = 0;
  int          req_total   = 0;
  int          we_total    = 0;
  int          wr_total    = 0;
  int          resp_total  = 0;

  assign bus.mem_ack   = bus.mem_req & ~hang;
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_total <= wr_total + 1;
    end
    if (bus.stall)                 stall_total <= stall_total + 1;
    if (bus.mem_req)               req_total   <= req_total + 1;
    if (bus.mem_req && bus.mem_we) we_total    <= we_total + 1;
    if (bus.resp_valid)            resp_total  <= resp_total + 1;
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_rdata[$];
  logic        sb_err[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_req, input int exp_we, input int exp_wr);
    int lat, s0, r0, w0, m0, k;
    bit seen;
    logic [31:0] e_rd;
    logic        e_err;
    sb_rdata.push_back(exp_rd);
    sb_err.push_back(exp_err);
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    s0 = stall_total; r0 = req_total; w0 = we_total; m0 = wr_total;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    check({tag, " resp_seen"}, 32'(seen), 32'd1);
    e_rd  = sb_rdata.pop_front();
    e_err = sb_err.pop_front();
    if (seen) begin
      check({tag, " rdata"}, bus.resp_rdata, e_rd);
      check({tag, " err"}, 32'(bus.resp_err), 32'(e_err));
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " ready_in_resp"}, 32'(bus.req_ready), 32'd0);
      check({tag, " stall_cycles"}, 32'(stall_total - s0), 32'(exp_req));
      check({tag, " mem_req_cycles"}, 32'(req_total - r0), 32'(exp_req));
      check({tag, " mem_we_cycles"}, 32'(we_total - w0), 32'(exp_we));
      check({tag, " mem_writes"}, 32'(wr_total - m0), 32'(exp_wr));
      @(negedge clk);
      check({tag, " resp_pulse_end"}, 32'(bus.resp_valid), 32'd0);
    end
  endtask

  int r_snap;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready",  32'(bus.req_ready), 32'd1);
    check("rst mem_req",    32'(bus.mem_req), 32'd0);
    check("rst mem_we",     32'(bus.mem_we), 32'd0);
    check("rst mem_addr",   32'(bus.mem_addr), 32'd0);
    check("rst mem_wdata",  bus.mem_wdata, 32'd0);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_rdata", bus.resp_rdata, 32'd0);
    check("rst resp_err",   32'(bus.resp_err), 32'd0);
    check("rst stall",      32'(bus.stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store/load round trip.
    access("sw 0x10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 1, 1);
    check("sw mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    access("lw 0x10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 0);
    check("lw mem_addr", 32'(bus.mem_addr), 32'd4);

    // Extraction and sign extension.
    access("sw 0x10 b", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80112233, 32'h0, 1'b0, 2, 1, 1, 1);
    access("lb 0x13",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 0);
    access("lbu 0x13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0, 2, 1, 0, 0);
    access("lh 0x12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8011, 1'b0, 2, 1, 0, 0);
    access("lbu 0x10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h00000033, 1'b0, 2, 1, 0, 0);
    access("lw wrap",  1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 32'h80112233, 1'b0, 2, 1, 0, 0);

    // Read-modify-write sub-word stores.
    access("sw 0x20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 1, 1, 1);
    access("sb 0x21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h123456AA, 32'h0, 1'b0, 3, 2, 1, 1);
    check("sb mem_wdata", bus.mem_wdata, 32'h1122AA44);
    access("lw 0x20 a", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0, 2, 1, 0, 0);
    access("sh 0x22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h7777BEEF, 32'h0, 1'b0, 3, 2, 1, 1);
    access("lhu 0x22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000BEEF, 1'b0, 2, 1, 0, 0);
    access("lh 0x20",  1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'hFFFFAA44, 1'b0, 2, 1, 0, 0);

    // Illegal accesses never touch memory.
    access("lh 0x01",   1'b0, 2'b01, 1'b1, 32'h01, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
    access("size 11",   1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
    access("sw 0x22",   1'b1, 2'b10, 1'b0, 32'h22, 32'h5A5A5A5A, 32'h0, 1'b1, 1, 0, 0, 0);

    // Memory never acks: the RMW read times out and the write is never issued.
    hang = 1'b1;
    access("sb timeout", 1'b1, 2'b00, 1'b0, 32'h20, 32'h00000055, 32'h0, 1'b1, 5, 4, 0, 0);
    check("timeout mem_req", 32'(bus.mem_req), 32'd0);
    hang = 1'b0;
    access("lw after to", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0, 2, 1, 0, 0);

    // Reset while a read is outstanding.
    hang = 1'b1;
    r_snap = resp_total;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h10;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mid stall", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid rst mem_req", 32'(bus.mem_req), 32'd0);
    check("mid rst ready",   32'(bus.req_ready), 32'd1);
    hang = 1'b0;
    repeat (3) @(negedge clk);
    check("mid rst no resp", 32'(resp_total - r_snap), 32'd0);
    access("lw after rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80112233, 1'b0, 2, 1, 0, 0);

    check("scoreboard empty", 32'(sb_rdata.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
